// File: rtl/dmem_lsu_pkg.sv
// Shared encodings and helpers for the data-memory load/store unit.
package dmem_lsu_pkg;

  localparam int unsigned DEF_MEM_BYTES = 256;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_X = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

  // Misaligned, illegal-size or out-of-range request.
  function automatic logic access_fault(input logic [1:0]  sz,
                                        input logic [31:0] addr,
                                        input int unsigned mem_bytes);
    logic f;
    case (size_e'(sz))
      SZ_H:    f = addr[0];
      SZ_W:    f = |addr[1:0];
      SZ_X:    f = 1'b1;
      default: f = 1'b0;
    endcase
    return f | (addr >= mem_bytes);
  endfunction

endpackage

// File: rtl/dmem_lsu_align.sv
// Lane steering: sub-word store merge and load extract/extend (little-endian).
module dmem_lsu_align
  import dmem_lsu_pkg::*;
(
  input  logic [31:0] old_word_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  lane_i,
  output logic [31:0] merged_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = old_word_i[{lane_i, 3'b000} +: 8];
  assign half_sel = old_word_i[{lane_i[1], 4'b0000} +: 16];

  // Replace only the addressed byte/half of the old word.
  always_comb begin
    merged_o = old_word_i;
    case (size_e'(size_i))
      SZ_B:    merged_o[{lane_i, 3'b000} +: 8]     = wdata_i[7:0];
      SZ_H:    merged_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      SZ_W:    merged_o = wdata_i;
      default: merged_o = old_word_i;
    endcase
  end

  // Pick the addressed lane and sign- or zero-extend it.
  always_comb begin
    rdata_o = '0;
    case (size_e'(size_i))
      SZ_B:    rdata_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
      SZ_H:    rdata_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
      SZ_W:    rdata_o = old_word_i;
      default: rdata_o = '0;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit: latches one request, performs a word-aligned access
// (read-modify-write for sub-word stores) and returns a one-cycle response.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = DEF_MEM_BYTES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  state_e      state_q, state_d;
  logic        we_q, uns_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_fault_q, rsp_fault_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        accept, req_fault;
  logic [31:0] merged, extracted;

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid & req_ready;
  // Evaluated on the same values that get latched on this edge.
  assign req_fault = access_fault(req_size, req_addr, MEM_BYTES);

  dmem_lsu_align u_align (
    .old_word_i (mem_rd),
    .wdata_i    (wdata_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .lane_i     (addr_q[1:0]),
    .merged_o   (merged),
    .rdata_o    (extracted)
  );

  // Request latch: captured once at accept, ignored afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      uns_q   <= req_unsigned;
      size_q  <= req_size;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // State and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_fault_q <= rsp_fault_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Next state and next response; response data holds between responses.
  always_comb begin
    state_d     = state_q;
    rsp_valid_d = 1'b0;
    rsp_fault_d = rsp_fault_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_fault) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_fault_d = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_fault_d = 1'b0;
        rsp_rdata_d = we_q ? '0 : extracted;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_fault = rsp_fault_q;
  assign rsp_rdata = rsp_rdata_q;
  assign mem_a     = {addr_q[31:2], 2'b00};
  // Reset gating keeps a reset during EXEC from committing a write.
  assign mem_we    = (state_q == EXEC) & we_q & ~reset;
  assign mem_wd    = ((state_q == EXEC) && we_q) ? merged : '0;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed self-checking bench for dmem_lsu with a behavioural word memory.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_fault, mem_we;
  logic [31:0] rsp_rdata, mem_a, mem_wd, mem_rd;

  logic [31:0] mem [64];

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Results collected by do_req.
  int unsigned lat, we_cnt;
  logic [31:0] we_a, we_d, r_data;
  logic        r_fault;

  // Back-to-back bookkeeping.
  logic [8:0]  rdy_pat;
  logic [31:0] rsp_seen [4];
  int unsigned n_acc, n_rsp;

  always #5 clk = ~clk;

  dmem_lsu #(.MEM_BYTES(256)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_fault    (rsp_fault),
    .mem_we       (mem_we),
    .mem_a        (mem_a),
    .mem_wd       (mem_wd),
    .mem_rd       (mem_rd)
  );

  assign mem_rd = mem[mem_a[7:2]];

  always @(posedge clk) if (mem_we) mem[mem_a[7:2]] <= mem_wd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request, scramble the inputs after accept, then watch up to
  // 6 cycles for write strobes and the response pulse.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = ~we; req_size = ~sz; req_unsigned = ~u;
    req_addr = a ^ 32'h4; req_wdata = ~wd;
    lat = 99; we_cnt = 0; we_a = '0; we_d = '0; r_data = 'x; r_fault = 1'bx;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (mem_we) begin we_cnt++; we_a = mem_a; we_d = mem_wd; end
      if (rsp_valid) begin lat = i; r_data = rsp_rdata; r_fault = rsp_fault; break; end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    foreach (mem[i]) mem[i] = 32'h0;
    mem[0]  = 32'h5A5A5A5A;
    mem[1]  = 32'h11223344;
    mem[2]  = 32'h0000000C;
    mem[8]  = 32'h01010101;
    mem[9]  = 32'h02020202;
    mem[10] = 32'h03030303;
    mem[63] = 32'h77000000;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    reset = 1'b1;
    #1;
    chk("rst_ready",  req_ready, 1);
    chk("rst_rvalid", rsp_valid, 0);
    chk("rst_rdata",  rsp_rdata, 0);
    chk("rst_fault",  rsp_fault, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_a",  mem_a, 0);
    chk("rst_mem_wd", mem_wd, 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // Word store then load.
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    chk("sw_we_cnt", we_cnt, 1);
    chk("sw_mem_a",  we_a, 32'h10);
    chk("sw_mem_wd", we_d, 32'hDEADBEEF);
    chk("sw_lat",    lat, 2);
    chk("sw_fault",  r_fault, 0);
    chk("sw_rdata",  r_data, 0);
    chk("sw_mem",    mem[4], 32'hDEADBEEF);
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("lw_lat",    lat, 2);
    chk("lw_rdata",  r_data, 32'hDEADBEEF);
    chk("lw_fault",  r_fault, 0);
    chk("lw_we_cnt", we_cnt, 0);
    chk("hold_rdata", rsp_rdata, 32'hDEADBEEF);

    // Byte merge and byte loads.
    do_req(1'b1, 2'b00, 1'b0, 32'h09, 32'h123456AB);
    chk("sb_mem_a",  we_a, 32'h08);
    chk("sb_mem_wd", we_d, 32'h0000AB0C);
    chk("sb_mem",    mem[2], 32'h0000AB0C);
    do_req(1'b0, 2'b00, 1'b0, 32'h09, 32'h0);
    chk("lb_rdata",  r_data, 32'hFFFFFFAB);
    do_req(1'b0, 2'b00, 1'b1, 32'h09, 32'h0);
    chk("lbu_rdata", r_data, 32'h000000AB);
    do_req(1'b0, 2'b00, 1'b1, 32'hFF, 32'h0);
    chk("lbu_top_fault", r_fault, 0);
    chk("lbu_top_rdata", r_data, 32'h00000077);

    // Halfword merge and loads.
    do_req(1'b1, 2'b01, 1'b0, 32'h06, 32'hFFFF8001);
    chk("sh_mem_wd", we_d, 32'h80013344);
    chk("sh_mem",    mem[1], 32'h80013344);
    do_req(1'b0, 2'b01, 1'b0, 32'h06, 32'h0);
    chk("lh_rdata",  r_data, 32'hFFFF8001);
    do_req(1'b0, 2'b01, 1'b1, 32'h06, 32'h0);
    chk("lhu_rdata", r_data, 32'h00008001);

    // Faults.
    do_req(1'b0, 2'b10, 1'b0, 32'h02, 32'h0);
    chk("f_lw_lat",   lat, 1);
    chk("f_lw_fault", r_fault, 1);
    chk("f_lw_rdata", r_data, 0);
    chk("f_lw_we",    we_cnt, 0);
    do_req(1'b1, 2'b01, 1'b0, 32'h03, 32'h1234);
    chk("f_sh_lat",   lat, 1);
    chk("f_sh_fault", r_fault, 1);
    chk("f_sh_we",    we_cnt, 0);
    do_req(1'b0, 2'b11, 1'b0, 32'h00, 32'h0);
    chk("f_sz_lat",   lat, 1);
    chk("f_sz_fault", r_fault, 1);
    chk("f_sz_rdata", r_data, 0);
    do_req(1'b1, 2'b10, 1'b0, 32'h100, 32'hCAFEF00D);
    chk("f_oor_lat",   lat, 1);
    chk("f_oor_fault", r_fault, 1);
    chk("f_oor_we",    we_cnt, 0);
    chk("f_oor_mem",   mem[0], 32'h5A5A5A5A);

    // Back-to-back with req_valid held high.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h20; req_wdata = '0;
    n_acc = 0; n_rsp = 0; rdy_pat = '0;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clk);
      rdy_pat[i] = req_ready;
      if (rsp_valid && n_rsp < 4) begin rsp_seen[n_rsp] = rsp_rdata; n_rsp++; end
      if (req_ready && req_valid) begin
        n_acc++;
        @(posedge clk); #1;
        if (n_acc == 3) req_valid = 1'b0;
        else req_addr = req_addr + 32'h4;
      end
    end
    chk("b2b_ready_pat", {23'b0, rdy_pat}, 32'h049);
    chk("b2b_accepts", n_acc, 3);
    chk("b2b_rsp_cnt", n_rsp, 3);
    chk("b2b_rsp0", rsp_seen[0], 32'h01010101);
    chk("b2b_rsp1", rsp_seen[1], 32'h02020202);
    chk("b2b_rsp2", rsp_seen[2], 32'h03030303);

    // Reset asserted during a byte store's EXEC cycle.
    @(negedge clk);
    chk("pre_rst_rdata", rsp_rdata, 32'h03030303);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h08; req_wdata = 32'h55;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("mid_exec_we", mem_we, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_we",     mem_we, 0);
    chk("mid_rst_ready",  req_ready, 1);
    chk("mid_rst_rvalid", rsp_valid, 0);
    chk("mid_rst_rdata",  rsp_rdata, 0);
    chk("mid_rst_fault",  rsp_fault, 0);
    chk("mid_rst_mem_a",  mem_a, 0);
    chk("mid_rst_mem_wd", mem_wd, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", req_ready, 1);
    chk("post_rst_mem",   mem[2], 32'h0000AB0C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
